// File: rtl/aba_ram_param_pkg.sv
// Shared definitions for the Jaguar on-chip RAM family.
//  - read latency limits
//  - clear/ready FSM state encoding
//  - byte-lane count derivation and parameter legality check
package jag_mem_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // One write-enable lane per byte of the data word.
  function automatic int bew_f(input int dw);
    return dw / 8;
  endfunction

  function automatic bit params_ok(input int dw, input int rd_lat);
    return (dw > 0) && (dw % 8 == 0) &&
           (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/aba_ram_param_if.sv
// Bus bundle between a z-bus client and an aba_ram_param instance.
// Bit 0 of every vector is the MSB, matching the netlist RAM naming.
//  cs, we, bel : active-low access controls (bel[0] = z_in[0:7])
//  a, z_in     : word address and write data
//  z_out, z_oe : read data and its all-ones output enable
//  busy        : post-reset clear in progress
interface aba_ram_param_if
  import jag_mem_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 10
) ();
  localparam int BEW = bew_f(DW);

  logic            cs;
  logic            we;
  logic [0:BEW-1]  bel;
  logic [0:AW-1]   a;
  logic [0:DW-1]   z_in;
  logic [0:DW-1]   z_out;
  logic [0:DW-1]   z_oe;
  logic            busy;

  modport master (output cs, we, bel, a, z_in, input z_out, z_oe, busy);
  modport slave  (input cs, we, bel, a, z_in, output z_out, z_oe, busy);
endinterface

// File: rtl/aba_ram_core.sv
// Behavioural single-port byte-lane RAM with a registered read port.
//  clk   : rising-edge clock
//  rst_n : synchronous active-low clear of the read register only
//  wren  : write strobe; be[i] selects byte lane d[8i+7:8i]
//  rden  : load read register from mem[addr]; otherwise it holds
//  q     : read register (1-cycle latency), little-endian bit order
// Write-before-read across cycles falls out naturally: a write at edge N
// is visible to a read sampled at edge N+1; a read at edge N sees old data.
module aba_ram_core #(
  parameter int DW  = 32,
  parameter int AW  = 10,
  parameter int BEW = DW / 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wren,
  input  logic           rden,
  input  logic [BEW-1:0] be,
  input  logic [AW-1:0]  addr,
  input  logic [DW-1:0]  d,
  output logic [DW-1:0]  q
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_q, rd_d;

  always_ff @(posedge clk) begin
    for (int i = 0; i < BEW; i++) begin
      if (wren && be[i]) mem[addr][8*i +: 8] <= d[8*i +: 8];
    end
  end

  always_comb rd_d = rden ? mem[addr] : rd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= rd_d;
  end

  assign q = rd_q;
endmodule

// File: rtl/aba_ram_param.sv
// Parametrised single-port synchronous RAM for GPU/DSP local memory and
// line buffers, driving the shared z bus via z_out/z_oe.
//  sys_clk : clock, all logic rising-edge
//  resetl  : synchronous reset, active low
//  bus     : slave side of aba_ram_param_if (cs/we/bel/a/z_in in,
//            z_out/z_oe/busy out)
// Reads return data RD_LAT cycles after the strobe with z_oe asserted on
// exactly that cycle. With CLR_EN the array is zeroed word by word after
// reset (2**AW cycles), during which all accesses are ignored.
module aba_ram_param
  import jag_mem_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 10,
  parameter int RD_LAT = 2,
  parameter int CLR_EN = 1
) (
  input logic             sys_clk,
  input logic             resetl,
  aba_ram_param_if.slave  bus
);
  localparam int BEW = bew_f(DW);
  localparam logic [AW:0] CLR_LAST = (AW+1)'(2**AW - 1);

  if (!params_ok(DW, RD_LAT)) begin : g_param_err
    $error("aba_ram_param: DW must be a multiple of 8 and RD_LAT 1..2");
  end

  // ---- clear sequencer ----
  state_e      state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;
  logic        busy;

  assign busy = (state_q == ST_CLEAR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CLR_LAST) state_d = ST_READY;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      state_q <= (CLR_EN != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- bus bit-order reversal (bus bit 0 = MSB) ----
  logic [DW-1:0]  d_rev, out_int;
  logic [AW-1:0]  addr_rev;
  logic [BEW-1:0] be_rev;

  always_comb begin
    for (int k = 0; k < DW;  k++) d_rev[DW-1-k]     = bus.z_in[k];
    for (int k = 0; k < AW;  k++) addr_rev[AW-1-k]  = bus.a[k];
    for (int k = 0; k < BEW; k++) be_rev[BEW-1-k]   = ~bus.bel[k];
  end

  always_comb begin
    for (int k = 0; k < DW; k++) bus.z_out[k] = out_int[DW-1-k];
  end

  // ---- access decode and core mux ----
  // Gating with resetl keeps the array untouched while reset is held.
  logic           rd_stb, wr_stb, core_wren;
  logic [AW-1:0]  core_addr;
  logic [BEW-1:0] core_be;
  logic [DW-1:0]  core_d, core_q;

  assign rd_stb    = resetl && !busy && !bus.cs &&  bus.we;
  assign wr_stb    = resetl && !busy && !bus.cs && !bus.we;
  assign core_wren = (resetl && busy) || wr_stb;
  assign core_addr = busy ? cnt_q[AW-1:0] : addr_rev;
  assign core_be   = busy ? '1 : be_rev;
  assign core_d    = busy ? '0 : d_rev;

  aba_ram_core #(.DW(DW), .AW(AW), .BEW(BEW)) u_core (
    .clk   (sys_clk),
    .rst_n (resetl),
    .wren  (core_wren),
    .rden  (rd_stb),
    .be    (core_be),
    .addr  (core_addr),
    .d     (core_d),
    .q     (core_q)
  );

  // ---- read-strobe pipeline: vld_pipe_q[k] = strobe k+1 cycles ago ----
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;

  assign vld_pipe_d = RD_LAT'({vld_pipe_q, rd_stb});

  always_ff @(posedge sys_clk) begin
    if (!resetl) vld_pipe_q <= '0;
    else         vld_pipe_q <= vld_pipe_d;
  end

  assign bus.z_oe = {DW{vld_pipe_q[RD_LAT-1]}};
  assign bus.busy = busy;

  // ---- output register: only reloads on read data, so idle holds it ----
  if (RD_LAT == 1) begin : g_lat1
    assign out_int = core_q;
  end else begin : g_lat2
    logic [DW-1:0] z_out_q, z_out_d;
    always_comb z_out_d = vld_pipe_q[0] ? core_q : z_out_q;
    always_ff @(posedge sys_clk) begin
      if (!resetl) z_out_q <= '0;
      else         z_out_q <= z_out_d;
    end
    assign out_int = z_out_q;
  end
endmodule

// File: tb/tb_aba_ram_param.sv
module tb_aba_ram_param;
  logic clk = 1'b0;
  logic resetl = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  aba_ram_param_if #(.DW(32), .AW(10)) bus0 ();
  aba_ram_param_if #(.DW(32), .AW(4))  bus1 ();

  aba_ram_param #(.DW(32), .AW(10), .RD_LAT(2), .CLR_EN(1)) u_dut0 (
    .sys_clk(clk), .resetl(resetl), .bus(bus0));
  aba_ram_param #(.DW(32), .AW(4), .RD_LAT(1), .CLR_EN(0)) u_dut1 (
    .sys_clk(clk), .resetl(resetl), .bus(bus1));

  typedef struct {
    bit          wr;
    logic [9:0]  a;
    logic [3:0]  bel;
    logic [31:0] d;    // write data, or expected read data
    string       nm;
  } vec_t;

  vec_t vt[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle0();
    bus0.cs = 1'b1; bus0.we = 1'b1; bus0.bel = 4'hF;
  endtask

  task automatic idle1();
    bus1.cs = 1'b1; bus1.we = 1'b1; bus1.bel = 4'hF;
  endtask

  task automatic wr0(input logic [9:0] a, input logic [31:0] d, input logic [3:0] bel);
    bus0.cs = 1'b0; bus0.we = 1'b0; bus0.a = a; bus0.z_in = d; bus0.bel = bel;
    tick();
    idle0();
    chk("wr_oe_p1", bus0.z_oe, 32'h0);
    tick();
    chk("wr_oe_p2", bus0.z_oe, 32'h0);
  endtask

  task automatic rd0(input logic [9:0] a, input logic [31:0] exp, input string nm);
    bus0.cs = 1'b0; bus0.we = 1'b1; bus0.a = a;
    tick();
    idle0();
    chk({nm, "_oe_p1"}, bus0.z_oe, 32'h0);
    tick();
    chk({nm, "_oe_p2"}, bus0.z_oe, 32'hFFFF_FFFF);
    chk({nm, "_data"}, bus0.z_out, exp);
    tick();
    chk({nm, "_oe_p3"}, bus0.z_oe, 32'h0);
    chk({nm, "_held"}, bus0.z_out, exp);
  endtask

  // Counts cycles from reset release until busy drops; optionally pokes a
  // write to 0x3 and a read while the clear is running.
  task automatic count_busy(input bit poke, output int n, output int bad);
    n = 0; bad = 0;
    while (bus0.busy === 1'b1 && n < 3000) begin
      if (poke && n == 10) begin
        bus0.cs = 1'b0; bus0.we = 1'b0; bus0.a = 10'h003;
        bus0.z_in = 32'h1234_5678; bus0.bel = 4'h0;
      end
      if (poke && n == 20) begin
        bus0.cs = 1'b0; bus0.we = 1'b1; bus0.a = 10'h003;
      end
      if (n == 11 || n == 21) idle0();
      tick();
      n++;
      if (bus0.z_oe !== 32'h0 || bus0.z_out !== 32'h0) bad++;
    end
  endtask

  initial begin
    int n, bad;
    vt[0]  = '{1'b0, 10'h000, 4'hF, 32'h0000_0000, "rd_clr_000"};
    vt[1]  = '{1'b0, 10'h3FF, 4'hF, 32'h0000_0000, "rd_clr_3ff"};
    vt[2]  = '{1'b0, 10'h003, 4'hF, 32'h0000_0000, "rd_blocked_003"};
    vt[3]  = '{1'b1, 10'h155, 4'h0, 32'hDEAD_BEEF, "wr_155"};
    vt[4]  = '{1'b0, 10'h155, 4'hF, 32'hDEAD_BEEF, "rd_155"};
    vt[5]  = '{1'b1, 10'h020, 4'h0, 32'h1122_3344, "wr_020_pre"};
    vt[6]  = '{1'b1, 10'h020, 4'h5, 32'hAABB_CCDD, "wr_020_bel0101"};
    vt[7]  = '{1'b0, 10'h020, 4'hF, 32'hAA22_CC44, "rd_020_lanes"};
    vt[8]  = '{1'b1, 10'h020, 4'hF, 32'h5555_5555, "wr_020_noop"};
    vt[9]  = '{1'b0, 10'h020, 4'hF, 32'hAA22_CC44, "rd_020_noop"};
    vt[10] = '{1'b1, 10'h021, 4'h0, 32'hCAFE_F00D, "wr_021"};
    vt[11] = '{1'b1, 10'h021, 4'hE, 32'h0000_0000, "wr_021_lsb"};
    vt[12] = '{1'b0, 10'h021, 4'hF, 32'hCAFE_F000, "rd_021"};
    vt[13] = '{1'b0, 10'h155, 4'hF, 32'hDEAD_BEEF, "rd_155_again"};

    idle0(); idle1();
    bus0.a = '0; bus0.z_in = '0; bus1.a = '0; bus1.z_in = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy0", {31'b0, bus0.busy}, 32'd1);
    chk("rst_oe0", bus0.z_oe, 32'h0);
    chk("rst_zout0", bus0.z_out, 32'h0);
    chk("rst_busy1", {31'b0, bus1.busy}, 32'd0);
    chk("rst_oe1", bus1.z_oe, 32'h0);
    chk("rst_zout1", bus1.z_out, 32'h0);

    // Clear sequence with a blocked write and read in the middle
    resetl = 1'b1;
    count_busy(1'b1, n, bad);
    chk("clr_cycles", n, 32'd1024);
    chk("clr_quiet", bad, 32'd0);
    chk("lat1_no_busy", {31'b0, bus1.busy}, 32'd0);

    // Table-driven accesses on the RD_LAT=2 instance
    for (int i = 0; i < 14; i++) begin
      if (vt[i].wr) wr0(vt[i].a, vt[i].d, vt[i].bel);
      else          rd0(vt[i].a, vt[i].d, vt[i].nm);
    end

    // Write then read same address on consecutive cycles -> new data
    wr0(10'h040, 32'hFFFF_FFFF, 4'h0);
    bus0.cs = 1'b0; bus0.we = 1'b0; bus0.a = 10'h040; bus0.z_in = 32'h0102_0304; bus0.bel = 4'h0;
    tick();
    bus0.we = 1'b1;
    tick();
    idle0();
    tick();
    chk("wr_rd_oe", bus0.z_oe, 32'hFFFF_FFFF);
    chk("wr_rd_data", bus0.z_out, 32'h0102_0304);
    tick();

    // Read then write same address next cycle -> read returns old data
    bus0.cs = 1'b0; bus0.we = 1'b1; bus0.a = 10'h040;
    tick();
    bus0.we = 1'b0; bus0.z_in = 32'h0A0B_0C0D; bus0.bel = 4'h0;
    tick();
    idle0();
    chk("rd_wr_oe", bus0.z_oe, 32'hFFFF_FFFF);
    chk("rd_wr_old", bus0.z_out, 32'h0102_0304);
    tick();
    rd0(10'h040, 32'h0A0B_0C0D, "rd_wr_new");

    // Back-to-back reads of two addresses
    bus0.cs = 1'b0; bus0.we = 1'b1; bus0.a = 10'h155;
    tick();
    bus0.a = 10'h020;
    tick();
    idle0();
    chk("b2b_oe1", bus0.z_oe, 32'hFFFF_FFFF);
    chk("b2b_d1", bus0.z_out, 32'hDEAD_BEEF);
    tick();
    chk("b2b_oe2", bus0.z_oe, 32'hFFFF_FFFF);
    chk("b2b_d2", bus0.z_out, 32'hAA22_CC44);
    tick();
    chk("b2b_oe3", bus0.z_oe, 32'h0);

    // RD_LAT=1 instance: data and oe one cycle after strobe, hold on idle
    bus1.cs = 1'b0; bus1.we = 1'b0; bus1.a = 4'h5; bus1.z_in = 32'h0BAD_F00D; bus1.bel = 4'h0;
    tick();
    bus1.a = 4'h0; bus1.z_in = 32'h89AB_CDEF;
    tick();
    bus1.we = 1'b1;
    tick();
    idle1();
    chk("lat1_oe", bus1.z_oe, 32'hFFFF_FFFF);
    chk("lat1_data", bus1.z_out, 32'h89AB_CDEF);
    tick();
    chk("lat1_idle_oe", bus1.z_oe, 32'h0);
    chk("lat1_held", bus1.z_out, 32'h89AB_CDEF);

    // Reset in the middle of a clear restarts the full sequence
    wr0(10'h3F0, 32'h7777_7777, 4'h0);
    resetl = 1'b0;
    tick(); tick();
    chk("rst2_zout", bus0.z_out, 32'h0);
    chk("rst2_busy", {31'b0, bus0.busy}, 32'd1);
    resetl = 1'b1;
    repeat (500) tick();
    chk("mid_busy", {31'b0, bus0.busy}, 32'd1);
    resetl = 1'b0;
    tick(); tick();
    resetl = 1'b1;
    count_busy(1'b0, n, bad);
    chk("reclr_cycles", n, 32'd1024);
    chk("reclr_quiet", bad, 32'd0);
    rd0(10'h3F0, 32'h0, "reclr_3f0");
    rd0(10'h155, 32'h0, "reclr_155");
    rd0(10'h020, 32'h0, "reclr_020");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
